// File: rtl/uart_rx_pkg.sv
// Shared types and divisor helpers for the UART receive path.
// Latency: none (compile-time constants and functions only).
// Backpressure: not applicable.
package uart_rx_pkg;

  // Receive sequencer states; PARITY is only reachable in parity builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD      = 9600;
  localparam int unsigned DEF_DATA_BITS = 8;

  // Clock cycles per bit period.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Cycles from the start edge to the centre of the start bit.
  function automatic int unsigned half_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return baud_div(clk_freq, baud) / 2;
  endfunction

  // Width of a counter holding 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the data-bit index, sized to hold 0..data_bits.
  function automatic int unsigned bit_idx_w(input int unsigned data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: wraps at BAUD_DIV-1, flags terminal and half-period counts.
// Latency: tc/half are decoded directly from the count register (0 cycles).
// Backpressure: none; clr has priority over en.
module uart_baud_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16,
  parameter int unsigned HALF_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic half
);

  localparam int unsigned CW = cnt_w(BAUD_DIV);
  localparam logic [CW-1:0] TC_VAL   = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_VAL = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc   = (cnt_q == TC_VAL);
  assign half = (cnt_q == HALF_VAL);

  // Next count: clear wins, otherwise count up and wrap after the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: start-edge strobe in, LSB-first byte out on valid/ready, error pulses.
// Latency: stop sample at t0+HALF_DIV+(DATA_BITS+1)*BAUD_DIV (+BAUD_DIV with parity), rx_valid next cycle.
// Backpressure: one-byte holding register; a byte finishing while one is pending is dropped with overrun_err.
// Optional even-parity stage is enabled by defining UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD      = DEF_BAUD,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h2l_sig,
  input  logic                 rx_sync,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF_DIV = half_div(CLK_FREQ, BAUD);
  localparam int unsigned IDX_W    = bit_idx_w(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;

  logic cnt_clr;
  logic cnt_en;
  logic baud_tc;
  logic baud_half;
  logic frame_pulse;
  logic overrun_pulse;

`ifdef UART_RX_PARITY_EN
  logic parity_bad_q, parity_bad_d;
  logic parity_pulse;
`endif

  // Counter runs in every active state and is held at zero while idle.
  assign cnt_en = (state_q != IDLE);

  uart_baud_cnt #(
    .BAUD_DIV (BAUD_DIV),
    .HALF_DIV (HALF_DIV)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (baud_tc),
    .half (baud_half)
  );

  // Next-state, bit assembly, holding-register update and error pulse decode.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = valid_q;
    cnt_clr       = 1'b0;
    frame_pulse   = 1'b0;
    overrun_pulse = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d  = parity_bad_q;
    parity_pulse  = 1'b0;
`endif

    // Consumer takes the pending byte; a load below may re-set valid this cycle.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (h2l_sig) begin
          state_d = START;
        end
      end

      START: begin
        if (baud_half) begin
          // Restart the bit period from the start-bit centre.
          cnt_clr = 1'b1;
          if (!rx_sync) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high: glitch, not a start bit.
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (baud_tc) begin
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_tc) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          parity_bad_d = (^shift_q) ^ rx_sync;
          state_d      = STOP;
        end
      end
`endif

      STOP: begin
        if (baud_tc) begin
          state_d = IDLE;
          // Only one error is reported per frame; framing takes precedence.
          if (!rx_sync) begin
            frame_pulse = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (parity_bad_q) begin
            parity_pulse = 1'b1;
          end
`endif
          else if (valid_q && !rx_ready) begin
            overrun_pulse = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign busy        = (state_q != IDLE);
  // Pulses are suppressed during reset so an abandoned frame reports nothing.
  assign frame_err   = frame_pulse & ~rst;
  assign overrun_err = overrun_pulse & ~rst;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_pulse & ~rst;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at CLK_FREQ=16, BAUD=1 (16 cycles per bit).
// Index k counts clock edges after the h2l_sig edge t0; outputs are observed
// mid-cycle before edge t0+k, i.e. the values that edge sees.
module tb_uart_rx_ctrl;

  localparam int CLK_FREQ  = 16;
  localparam int BAUD      = 1;
  localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NPB = 1;
`else
  localparam int NPB = 0;
`endif
  // Edge at which the stop bit is sampled: 8 + 9*16 = 152 (168 with parity).
  localparam int STOP_K = 8 + (DATA_BITS + 1 + NPB) * 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       h2l_sig;
  logic       rx_sync;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .h2l_sig     (h2l_sig),
    .rx_sync     (rx_sync),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  // Drive inputs for the next rising edge and settle before observing.
  task automatic step(input logic h, input logic rs, input logic rdy, input logic r);
    @(negedge clk);
    h2l_sig  = h;
    rx_sync  = rs;
    rx_ready = rdy;
    rst      = r;
    #1;
  endtask

  // Line level seen at edge k of a frame: bit j occupies edges 16j..16j+15.
  function automatic logic line_at(input int k, input logic [7:0] b,
                                   input logic stopb, input logic parb);
    int j;
    j = k / 16;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (NPB == 1 && j == 9) return parb;
    if (j == 9 + NPB) return stopb;
    return 1'b1;
  endfunction

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({rx_valid, busy, frame_err, overrun_err, parity_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b busy=%b fe=%b oe=%b pe=%b want all 0",
               rx_valid, busy, frame_err, overrun_err, parity_err);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h want 00", rx_data);
    end
  endtask

  // 0xA5 with rx_ready high; a second strobe mid-frame must be ignored.
  task automatic test_byte();
    logic [7:0] b;
    b = 8'hA5;
    for (int k = 0; k <= STOP_K + 3; k++) begin
      step((k == 0) || (k == 40), line_at(k, b, 1'b1, ^b), 1'b1, 1'b0);
      checks++;
      if (rx_valid !== (k == STOP_K + 1)) begin
        errors++;
        $display("FAIL byte_valid k=%0d got %b want %b", k, rx_valid, (k == STOP_K + 1));
      end
      checks++;
      if (busy !== (k >= 1 && k <= STOP_K)) begin
        errors++;
        $display("FAIL byte_busy k=%0d got %b want %b", k, busy, (k >= 1 && k <= STOP_K));
      end
      checks++;
      if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
        errors++;
        $display("FAIL byte_err k=%0d got %b want 000", k, {frame_err, overrun_err, parity_err});
      end
      if (k == STOP_K + 1) begin
        checks++;
        if (rx_data !== 8'hA5) begin
          errors++;
          $display("FAIL byte_data got %h want a5", rx_data);
        end
      end
    end
  endtask

  // Line returns high before the start-bit centre: silent return to IDLE.
  task automatic test_glitch();
    for (int k = 0; k <= 20; k++) begin
      step(k == 0, (k < 6) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      checks++;
      if (busy !== (k >= 1 && k <= 8)) begin
        errors++;
        $display("FAIL glitch_busy k=%0d got %b want %b", k, busy, (k >= 1 && k <= 8));
      end
      checks++;
      if ({rx_valid, frame_err, overrun_err, parity_err} !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_out k=%0d got %b want 0000", k,
                 {rx_valid, frame_err, overrun_err, parity_err});
      end
    end
  endtask

  // 0x3C with stop bit 0: one-cycle frame_err, nothing loaded.
  task automatic test_frame_err();
    logic [7:0] b;
    b = 8'h3C;
    for (int k = 0; k <= STOP_K + 3; k++) begin
      step(k == 0, line_at(k, b, 1'b0, ^b), 1'b1, 1'b0);
      checks++;
      if (frame_err !== (k == STOP_K)) begin
        errors++;
        $display("FAIL ferr_pulse k=%0d got %b want %b", k, frame_err, (k == STOP_K));
      end
      checks++;
      if ({rx_valid, overrun_err, parity_err} !== 3'b000) begin
        errors++;
        $display("FAIL ferr_other k=%0d got %b want 000", k, {rx_valid, overrun_err, parity_err});
      end
    end
  endtask

  // 0x3C held with rx_ready low, then 0xC3 overruns; then release.
  task automatic test_overrun();
    logic [7:0] b;
    b = 8'h3C;
    for (int k = 0; k <= STOP_K + 2; k++) begin
      step(k == 0, line_at(k, b, 1'b1, ^b), 1'b0, 1'b0);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL ovr_first got valid=%b data=%h want 1 3c", rx_valid, rx_data);
    end
    b = 8'hC3;
    for (int k = 0; k <= STOP_K + 2; k++) begin
      step(k == 0, line_at(k, b, 1'b1, ^b), 1'b0, 1'b0);
      checks++;
      if (overrun_err !== (k == STOP_K)) begin
        errors++;
        $display("FAIL ovr_pulse k=%0d got %b want %b", k, overrun_err, (k == STOP_K));
      end
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h3C || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL ovr_hold k=%0d got valid=%b data=%h fe=%b want 1 3c 0",
                 k, rx_valid, rx_data, frame_err);
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_accept got %b want 1", rx_valid);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drop got %b want 0", rx_valid);
    end
  endtask

  // 0x3C pending; 0x55 stop sample coincides with the consume: no overrun.
  task automatic test_back_to_back();
    logic [7:0] b;
    b = 8'h3C;
    for (int k = 0; k <= STOP_K + 2; k++) begin
      step(k == 0, line_at(k, b, 1'b1, ^b), 1'b0, 1'b0);
    end
    b = 8'h55;
    for (int k = 0; k <= STOP_K + 2; k++) begin
      step(k == 0, line_at(k, b, 1'b1, ^b), (k == STOP_K), 1'b0);
      checks++;
      if (overrun_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ovr k=%0d got %b want 0", k, overrun_err);
      end
      if (k == STOP_K) begin
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
          errors++;
          $display("FAIL b2b_before got valid=%b data=%h want 1 3c", rx_valid, rx_data);
        end
      end
      if (k == STOP_K + 1) begin
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
          errors++;
          $display("FAIL b2b_after got valid=%b data=%h want 1 55", rx_valid, rx_data);
        end
      end
    end
  endtask

  // Reset during data bit 4 with 0x55 pending, then a clean 0x81 frame.
  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h81;
    for (int k = 0; k <= 86; k++) begin
      step(k == 0, line_at(k, b, 1'b1, ^b), 1'b0, (k == 85));
    end
    checks++;
    if ({rx_valid, busy, frame_err, overrun_err, parity_err} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_flags got valid=%b busy=%b fe=%b oe=%b pe=%b want all 0",
               rx_valid, busy, frame_err, overrun_err, parity_err);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_data got %h want 00", rx_data);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    for (int k = 0; k <= STOP_K + 3; k++) begin
      step(k == 0, line_at(k, b, 1'b1, ^b), 1'b1, 1'b0);
      checks++;
      if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
        errors++;
        $display("FAIL rx81_err k=%0d got %b want 000", k, {frame_err, overrun_err, parity_err});
      end
      if (k == STOP_K + 1) begin
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
          errors++;
          $display("FAIL rx81_data got valid=%b data=%h want 1 81", rx_valid, rx_data);
        end
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  // 0x81 has even weight so the correct parity bit is 0; send 1.
  task automatic test_parity();
    logic [7:0] b;
    b = 8'h81;
    for (int k = 0; k <= STOP_K + 3; k++) begin
      step(k == 0, line_at(k, b, 1'b1, 1'b1), 1'b1, 1'b0);
      checks++;
      if (parity_err !== (k == STOP_K)) begin
        errors++;
        $display("FAIL par_pulse k=%0d got %b want %b", k, parity_err, (k == STOP_K));
      end
      checks++;
      if ({rx_valid, frame_err, overrun_err} !== 3'b000) begin
        errors++;
        $display("FAIL par_other k=%0d got %b want 000", k, {rx_valid, frame_err, overrun_err});
      end
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    h2l_sig  = 1'b0;
    rx_sync  = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX path. It is triggered by the one-cycle high-to-low strobe from the RX line edge detector. It times the start, data and stop bits with a baud counter and samples the synchronized line at bit centres. Each assembled byte is delivered through a valid/ready handshake, with framing and overrun errors reported as one-cycle pulses.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer), HALF_DIV = BAUD_DIV/2
DATA_BITS, 8, data bits per frame (5..8), LSB first

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
h2l_sig  in  1  one-cycle start-edge strobe from the edge detector
rx_sync  in  1  synchronized RX line level (already double-registered)
rx_data  out  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  out  1  byte available
rx_ready  in  1  consumer accepts byte when rx_valid&&rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overrun_err  out  1  one-cycle pulse: byte completed while previous still pending
parity_err  out  1  one-cycle pulse: parity mismatch (constant 0 without macro)
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, baud counter=0, bit index=0, shift reg=0, rx_data=0. rx_valid, frame_err, overrun_err, parity_err and busy are all 0. Reset mid-frame abandons the frame; no pulse is emitted.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: h2l_sig=1 moves to START with counter=0. h2l_sig is ignored in every other state.
- START: count 0..HALF_DIV-1. At HALF_DIV-1, sample rx_sync:
  - 0: go to DATA, counter=0, bit index=0.
  - 1: false start; return to IDLE silently.
- DATA: count 0..BAUD_DIV-1, wrapping to 0. At terminal count, shift rx_sync in at the MSB and shift right (LSB-first). After the DATA_BITS-th sample, go to PARITY (macro) or STOP.
- STOP: at terminal count BAUD_DIV-1, sample rx_sync, then return to IDLE the same cycle.
  - 1 with rx_valid=0, or rx_valid&&rx_ready in the same cycle: rx_data<=shift reg, rx_valid<=1.
  - 1 with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun_err pulses.
  - 0: frame_err pulses, no load, rx_valid unaffected.
- Handshake: rx_valid stays high until rx_valid&&rx_ready, then clears the next cycle. A simultaneous consume and load leaves rx_valid=1 with the new data and no overrun.
- Latency: h2l_sig high at edge t0 → start sample at t0+HALF_DIV. Stop sample at t0+HALF_DIV+(DATA_BITS+1)*BAUD_DIV. rx_valid is high from the following cycle. With PARITY, add BAUD_DIV.
- Counters are sized $clog2(BAUD_DIV) and $clog2(DATA_BITS+1). No overflow is possible.
- Error pulses are exactly one cycle wide and never overlap for the same frame.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state follows DATA. It samples one bit at terminal count and checks even parity (XOR of data bits and parity bit must be 0), then goes to STOP. On mismatch, the STOP stage still runs and framing is checked. The byte is not loaded and parity_err pulses at the stop sample; if framing also fails, only frame_err pulses.
- Undefined: no PARITY state; parity_err tied 0.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - baud divisor and half-divisor constants/function derived from CLK_FREQ/BAUD
  - DATA_BITS width constant
- Sub-module uart_baud_cnt: clear input, enable input, terminal-count and half-count outputs. It is instantiated once.

Test Plan:
All tests use CLK_FREQ=16, BAUD=1, so BAUD_DIV=16 and HALF_DIV=8.
- Byte 0xA5 with rx_ready=1: h2l_sig at t0 → rx_valid=1 at t0+153, rx_data=0xA5, no error pulses, busy low after the stop sample.
- Glitch: h2l_sig, then rx_sync high again before cycle 8 → no rx_valid, no errors, busy back to 0 at t0+9.
- Stop bit 0 on byte 0x3C → frame_err pulses exactly 1 cycle at t0+152, rx_valid stays 0.
- rx_ready=0, bytes 0x3C then 0xC3 → rx_data stays 0x3C, overrun_err pulses once. Then raise rx_ready → rx_valid drops next cycle.
- rx_ready asserted in the same cycle as the stop sample of 0x55 while 0x3C is pending → rx_data=0x55, rx_valid stays 1, no overrun.
- rst=1 at bit 4 of a frame → all outputs 0 next cycle. A following 0x81 frame is received correctly. With UART_RX_PARITY_EN, 0x81 plus parity 1 → parity_err pulse and no load.
